// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 4-digit active-low 7-segment bus, one frame at a time.
// Capture lands 2 + STABLE_CYCLES edges after a pin change; frame_valid follows the 4th capture by one edge.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_ok,
  output logic        frame_valid,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0]  seg_s1, seg_s2;
  logic [3:0]  an_s1, an_s2;
  logic [10:0] prev;
  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  mask, mask_n;
  logic [15:0] shadow, shadow_n;
  logic [3:0]  shadow_ok, shadow_ok_n;

  logic [10:0] samp;
  logic        changed;
  logic        capture;
  logic [3:0]  cap_an;
  logic [6:0]  cap_seg;
  logic        onehot;
  logic        multi;
  logic [4:0]  dec;
  logic        cap_err;
  logic        publish;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {1'b1, 4'd0};
      7'b1111001: decode = {1'b1, 4'd1};
      7'b0100100: decode = {1'b1, 4'd2};
      7'b0110000: decode = {1'b1, 4'd3};
      7'b0011001: decode = {1'b1, 4'd4};
      7'b0010010: decode = {1'b1, 4'd5};
      7'b0000010: decode = {1'b1, 4'd6};
      7'b1111000: decode = {1'b1, 4'd7};
      7'b0000000: decode = {1'b1, 4'd8};
      7'b0010000: decode = {1'b1, 4'd9};
      default:    decode = {1'b0, 4'hF};
    endcase
  endfunction

  assign samp    = {an_s2, seg_s2};
  assign changed = (samp != prev);
  assign capture = (state == SETTLE) && (cnt == STABLE);
  // prev holds the value that was counted stable, so it is what gets captured
  assign cap_an  = prev[10:7];
  assign cap_seg = prev[6:0];
  assign onehot  = $onehot(cap_an);
  assign multi   = (cap_an != 4'b0000) && !onehot;
  assign dec     = decode(cap_seg);
  assign cap_err = capture && (multi || (onehot && !dec[4]));
  assign publish = (mask == 4'b1111);

  always_comb begin
    shadow_n    = shadow;
    shadow_ok_n = shadow_ok;
    mask_n      = mask;
    if (capture && onehot) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_an[i]) begin
          shadow_n[4*i +: 4] = dec[3:0];
          shadow_ok_n[i]     = dec[4];
          mask_n[i]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1      <= '0;
      seg_s2      <= '0;
      an_s1       <= '0;
      an_s2       <= '0;
      prev        <= '0;
      state       <= IDLE;
      cnt         <= '0;
      mask        <= '0;
      shadow      <= 16'hFFFF;
      shadow_ok   <= 4'b0000;
      digits      <= 16'hFFFF;
      digit_ok    <= 4'b0000;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      an_s1  <= an_in;
      an_s2  <= an_s1;
      prev   <= samp;

      case (state)
        IDLE: begin
          if (changed) begin
            state <= SETTLE;
            cnt   <= 8'd1;
          end
        end
        SETTLE: begin
          if (capture) begin
            state <= changed ? SETTLE : HOLD;
            cnt   <= changed ? 8'd1 : cnt;
          end else if (changed) begin
            cnt <= 8'd1;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (changed) begin
            state <= SETTLE;
            cnt   <= 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      shadow    <= shadow_n;
      shadow_ok <= shadow_ok_n;
      err       <= cap_err;

      // forwarding shadow_n lets a capture on the publishing edge join the frame
      if (publish) begin
        digits      <= shadow_n;
        digit_ok    <= shadow_ok_n;
        frame_valid <= 1'b1;
        mask        <= 4'b0000;
      end else begin
        frame_valid <= 1'b0;
        mask        <= mask_n;
      end
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4 (legal 2..255): consecutive identical synchronized samples required to accept a digit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  7  active-low segment lines; bit0=a ... bit6=g.
REQ-005 an_in  input  4  active-high digit strobes; bit i selects digit i.
REQ-006 digits  output  16  last complete frame, BCD; digit i at [4i+3:4i]; 4'hF for an undecodable digit.
REQ-007 digit_ok  output  4  per-digit decode-valid flags for the frame in digits.
REQ-008 frame_valid  output  1  one-cycle pulse when digits/digit_ok update.
REQ-009 err  output  1  one-cycle pulse on an illegal pattern or a multi-hot strobe.

Function
REQ-010 seg_in and an_in SHALL each pass through a two-flop synchronizer before any other use.
REQ-011 State machine SHALL have states IDLE, SETTLE and HOLD.
REQ-012 IDLE: any change of the synchronized {an,seg} from the previous sample -> SETTLE, stable counter = 1.
REQ-013 SETTLE: unchanged sample increments the counter; a changed sample restarts the counter at 1 and stays in SETTLE.
REQ-014 SETTLE with counter = STABLE_CYCLES -> capture edge, then HOLD.
REQ-015 HOLD: no further captures; a changed sample -> SETTLE, counter = 1.
REQ-016 A capture with an = 4'b0000 (blanked) SHALL be ignored silently.
REQ-017 A capture with more than one strobe bit set SHALL be ignored and SHALL pulse err.
REQ-018 A capture with a one-hot strobe SHALL decode seg into shadow digit i and set capture mask bit i.
REQ-019 The decode table SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bits g..a).
REQ-020 Any other seg code SHALL store 4'hF with ok=0 in the shadow and SHALL pulse err.
REQ-021 A repeated capture of the same digit before frame completion SHALL overwrite its shadow entry.
REQ-022 When the capture mask becomes 4'b1111, the next edge SHALL copy all shadows to digits/digit_ok, pulse frame_valid and clear the mask.
REQ-023 A capture on the same edge that completes the mask SHALL be included in the published frame.
REQ-024 digits and digit_ok SHALL change only with a frame_valid pulse.
REQ-025 err SHALL be registered and asserted the cycle after the offending capture edge.
REQ-026 frame_valid and err MAY assert in the same cycle.
REQ-027 Latency from a stable pin change to its capture edge SHALL be 2 + STABLE_CYCLES cycles.
REQ-028 frame_valid SHALL assert one cycle after the fourth capture edge.
REQ-029 The stable counter SHALL saturate and never wrap.

Reset
REQ-030 While rst=1: state=IDLE, counter=0, mask=0, shadows=4'hF with ok=0, digits=16'hFFFF, digit_ok=4'b0000, frame_valid=0, err=0, synchronizers cleared.
REQ-031 rst asserted mid-frame SHALL discard the partial frame; no frame_valid SHALL be produced from pre-reset captures.

Verification
REQ-032 Scan an=0001/0010/0100/1000 with seg=0100100/0110000/0011001/0010010, 10 cycles each -> frame_valid once; digits=16'h5432, digit_ok=1111.
REQ-033 Hold an=0001, seg=1111001 for only STABLE_CYCLES+1 cycles, then 3 cycles -> capture only on the held sample; glitch sample never captured; err=0.
REQ-034 Digit 2 driven seg=1111111 during a full scan -> err pulse; digits[11:8]=4'hF, digit_ok=1011.
REQ-035 an=0011 held stable -> err pulse; mask unchanged; no frame_valid.
REQ-036 Assert rst after 3 digits are captured, then scan 9,8,7,6 -> exactly one frame_valid with digits=16'h6789; no pre-reset data published.
REQ-037 Scan digit 0 twice (value 1 then 7) before digits 1-3 -> published digits[3:0]=4'h7.
